// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between a first-word-fall-through FIFO and the UART transmit stage.
// The master side is the FIFO/host, the slave side is the transmitter.
interface fifo_uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tx_enable;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_empty;
   logic                  fifo_deQ;
   logic                  tx;
   logic                  busy;

   modport master (
      output tx_enable,
      output fifo_data,
      output fifo_empty,
      input  fifo_deQ,
      input  tx,
      input  busy
   );

   modport slave (
      input  tx_enable,
      input  fifo_data,
      input  fifo_empty,
      output fifo_deQ,
      output tx,
      output busy
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a fall-through FIFO: start bit, data LSB first,
// optional even parity, then 1 or 2 stop bits. All outputs are registered.
module fifo_uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_DIV   = 434,
   parameter int PARITY_EN  = 0,
   parameter int STOP_BITS  = 1
) (
   input logic           clock,
   input logic           reset,
   fifo_uart_tx_if.slave bus
);
   localparam int BW = $clog2(BAUD_DIV);
   localparam int CW = $clog2(DATA_WIDTH + 1);

   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]            state;
   logic [BW-1:0]         baud_cnt;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift;
   logic                  parity_bit;
   logic                  tx_q;
   logic                  busy_q;
   logic                  deq_q;
   logic                  baud_end;
   logic                  want_pop;

   assign baud_end = (baud_cnt == BAUD_LAST);
   assign want_pop = bus.tx_enable && !bus.fifo_empty;

   assign bus.tx       = tx_q;
   assign bus.busy     = busy_q;
   assign bus.fifo_deQ = deq_q;

   // The pop strobe is raised one cycle ahead of the start bit, so the head word
   // is latched on the same edge the FIFO advances; the word is still valid then.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         deq_q    <= 1'b0;
      end else begin
         deq_q <= 1'b0;
         if (state == IDLE || baud_end) baud_cnt <= '0;
         else                           baud_cnt <= baud_cnt + BAUD_ONE;

         case (state)
            IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (deq_q) begin
                  state   <= START;
                  bit_cnt <= '0;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end else if (want_pop) begin
                  deq_q <= 1'b1;
               end
            end
            START: begin
               if (baud_end) begin
                  state <= DATA;
                  tx_q  <= shift[0];
               end
            end
            DATA: begin
               if (baud_end) begin
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        state <= PARITY;
                        tx_q  <= parity_bit;
                     end else begin
                        state <= STOP;
                        tx_q  <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CNT_ONE;
                     tx_q    <= shift[1];
                  end
               end
            end
            PARITY: begin
               if (baud_end) begin
                  state <= STOP;
                  tx_q  <= 1'b1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  if (bit_cnt == STOP_LAST) begin
                     state   <= IDLE;
                     busy_q  <= 1'b0;
                     bit_cnt <= '0;
                     deq_q   <= want_pop;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_ONE;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Frame data path: loaded on the pop cycle, shifted at each data bit boundary.
   always_ff @(posedge clock) begin
      if (state == IDLE && deq_q) begin
         shift      <= bus.fifo_data;
         parity_bit <= ^bus.fifo_data;
      end else if (state == DATA && baud_end) begin
         shift <= shift >> 1;
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: two transmitters (8N1 and 8E2, 4 clocks per bit) each fed by a small FIFO model.
module tb_fifo_uart_tx;
   localparam int BD = 4;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   fifo_uart_tx_if #(.DATA_WIDTH(8)) bus0 ();
   fifo_uart_tx_if #(.DATA_WIDTH(8)) bus1 ();

   fifo_uart_tx #(.DATA_WIDTH(8), .BAUD_DIV(BD), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
      .clock(clock), .reset(reset), .bus(bus0));
   fifo_uart_tx #(.DATA_WIDTH(8), .BAUD_DIV(BD), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
      .clock(clock), .reset(reset), .bus(bus1));

   int checks   = 0;
   int failures = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic pop_next0 = 1'b0;
   logic pop_next1 = 1'b0;
   logic prev_deq0 = 1'b0;
   int   deq_count0 = 0;
   int   deq_count1 = 0;
   int   deq_bad0   = 0;

   // FIFO models: a pop strobe seen mid-cycle removes the head after the DUT has latched it.
   always @(negedge clock) begin
      if (bus0.fifo_deQ === 1'b1 && (bus0.fifo_empty === 1'b1 || prev_deq0 === 1'b1)) deq_bad0++;
      if (bus0.fifo_deQ === 1'b1) deq_count0++;
      prev_deq0 = bus0.fifo_deQ;
      if (pop_next0 && q0.size() > 0) q0.delete(0);
      pop_next0 = (bus0.fifo_deQ === 1'b1);
      bus0.fifo_empty = (q0.size() == 0);
      bus0.fifo_data  = (q0.size() > 0) ? q0[0] : 8'h00;
   end

   always @(negedge clock) begin
      if (bus1.fifo_deQ === 1'b1) deq_count1++;
      if (pop_next1 && q1.size() > 0) q1.delete(0);
      pop_next1 = (bus1.fifo_deQ === 1'b1);
      bus1.fifo_empty = (q1.size() == 0);
      bus1.fifo_data  = (q1.size() > 0) ? q1[0] : 8'h00;
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   function automatic logic busy_of(input int i);
      return (i == 0) ? bus0.busy : bus1.busy;
   endfunction

   function automatic logic tx_of(input int i);
      return (i == 0) ? bus0.tx : bus1.tx;
   endfunction

   // Waits (bounded) for busy, then records tx for every cycle busy stays high.
   task automatic capture(input int inst, input bit drop_en, output int gap, output int len,
                          output logic [127:0] wave);
      gap  = 0;
      len  = 0;
      wave = '0;
      while (busy_of(inst) !== 1'b1 && gap < 3000) begin
         gap++;
         tick();
      end
      while (busy_of(inst) === 1'b1 && len < 128) begin
         wave[len] = tx_of(inst);
         len++;
         if (drop_en && len == 1) bus0.tx_enable = 1'b0;
         tick();
      end
   endtask

   // bits[0] is the start bit; each bit is expected for BD consecutive cycles.
   function automatic int wave_err(input logic [127:0] w, input int len, input logic [15:0] bits);
      int e = 0;
      for (int c = 0; c < len; c++) if (w[c] !== bits[c / BD]) e++;
      return e;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      bus0.tx_enable = 1'b0;
      bus1.tx_enable = 1'b0;
      tick();
      tick();
      checks++; if (bus0.tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", bus0.tx); end
      checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
      checks++; if (bus0.fifo_deQ !== 1'b0) begin failures++; $display("FAIL reset_deq got=%b exp=0", bus0.fifo_deQ); end
      checks++; if (bus1.tx !== 1'b1) begin failures++; $display("FAIL reset_tx_b got=%b exp=1", bus1.tx); end
      reset = 1'b0;
      bus0.tx_enable = 1'b1;
      bus1.tx_enable = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int gap, len, c0;
      logic [127:0] w;
      c0 = deq_count0;
      q0.push_back(8'hA5);
      capture(0, 1'b0, gap, len, w);
      checks++; if (len !== 40) begin failures++; $display("FAIL single_len got=%0d exp=40", len); end
      checks++; if (wave_err(w, len, 16'b1101001010) !== 0) begin failures++; $display("FAIL single_wave got=%h", w[39:0]); end
      checks++; if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0) begin failures++; $display("FAIL single_after got tx=%b busy=%b exp tx=1 busy=0", bus0.tx, bus0.busy); end
      repeat (10) tick();
      checks++; if (deq_count0 - c0 !== 1) begin failures++; $display("FAIL single_pops got=%0d exp=1", deq_count0 - c0); end
   endtask

   task automatic test_parity();
      int gap, len;
      logic [127:0] w;
      q1.push_back(8'h07);
      capture(1, 1'b0, gap, len, w);
      checks++; if (len !== 48) begin failures++; $display("FAIL parity_len got=%0d exp=48", len); end
      checks++; if (wave_err(w, len, 16'b111000001110) !== 0) begin failures++; $display("FAIL parity_wave got=%h", w[47:0]); end
      checks++; if (deq_count1 !== 1) begin failures++; $display("FAIL parity_pops got=%0d exp=1", deq_count1); end
   endtask

   task automatic test_back_to_back();
      int gap, len, c0;
      logic [127:0] w;
      logic [15:0] exp_bits [3];
      exp_bits[0] = 16'b1010101010;
      exp_bits[1] = 16'b1000011110;
      exp_bits[2] = 16'b1111111110;
      c0 = deq_count0;
      q0.push_back(8'h55);
      q0.push_back(8'h0F);
      q0.push_back(8'hFF);
      for (int f = 0; f < 3; f++) begin
         capture(0, 1'b0, gap, len, w);
         if (f > 0) begin
            checks++; if (gap !== 1) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=1", f, gap); end
         end
         checks++; if (len !== 40) begin failures++; $display("FAIL b2b_len%0d got=%0d exp=40", f, len); end
         checks++; if (wave_err(w, len, exp_bits[f]) !== 0) begin failures++; $display("FAIL b2b_wave%0d got=%h", f, w[39:0]); end
         checks++; if (bus0.fifo_deQ !== (f < 2) || bus0.tx !== 1'b1) begin
            failures++; $display("FAIL b2b_gap_pop%0d got deq=%b tx=%b exp deq=%b tx=1", f, bus0.fifo_deQ, bus0.tx, f < 2);
         end
      end
      tick();
      checks++; if (q0.size() !== 0 || bus0.fifo_empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got size=%0d exp=0", q0.size()); end
      repeat (50) tick();
      checks++; if (deq_count0 - c0 !== 3) begin failures++; $display("FAIL b2b_pops got=%0d exp=3", deq_count0 - c0); end
   endtask

   task automatic test_empty();
      int bad = 0;
      int c0 = deq_count0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (bus0.tx !== 1'b1 || bus0.fifo_deQ !== 1'b0) bad++;
      end
      checks++; if (bad !== 0 || deq_count0 !== c0) begin failures++; $display("FAIL empty_idle got bad=%0d exp=0", bad); end
   endtask

   task automatic test_disabled();
      int gap, len, c0;
      logic [127:0] w;
      bus0.tx_enable = 1'b0;
      tick();
      c0 = deq_count0;
      q0.push_back(8'h3C);
      repeat (20) tick();
      checks++; if (deq_count0 !== c0 || bus0.busy !== 1'b0) begin failures++; $display("FAIL disabled_nopop got pops=%0d exp=0", deq_count0 - c0); end
      bus0.tx_enable = 1'b1;
      tick();
      checks++; if (bus0.fifo_deQ !== 1'b1 || bus0.busy !== 1'b0) begin failures++; $display("FAIL enable_pop got deq=%b busy=%b exp deq=1 busy=0", bus0.fifo_deQ, bus0.busy); end
      tick();
      checks++; if (bus0.tx !== 1'b0 || bus0.busy !== 1'b1) begin failures++; $display("FAIL enable_start got tx=%b busy=%b exp tx=0 busy=1", bus0.tx, bus0.busy); end
      capture(0, 1'b0, gap, len, w);
      checks++; if (len !== 40 || wave_err(w, len, 16'b1001111000) !== 0) begin failures++; $display("FAIL enable_frame got len=%0d wave=%h", len, w[39:0]); end
   endtask

   task automatic test_reset_mid();
      int gap, len, c0;
      logic [127:0] w;
      c0 = deq_count0;
      q0.push_back(8'hC3);
      q0.push_back(8'h5A);
      gap = 0;
      while (bus0.busy !== 1'b1 && gap < 3000) begin gap++; tick(); end
      repeat (17) tick();
      reset = 1'b1;
      tick();
      checks++; if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0 || bus0.fifo_deQ !== 1'b0) begin
         failures++; $display("FAIL resetmid_state got tx=%b busy=%b deq=%b exp 1 0 0", bus0.tx, bus0.busy, bus0.fifo_deQ);
      end
      reset = 1'b0;
      capture(0, 1'b0, gap, len, w);
      checks++; if (len !== 40 || wave_err(w, len, 16'b1010110100) !== 0) begin failures++; $display("FAIL resetmid_next got len=%0d wave=%h", len, w[39:0]); end
      repeat (5) tick();
      checks++; if (deq_count0 - c0 !== 2 || q0.size() !== 0) begin failures++; $display("FAIL resetmid_pops got=%0d exp=2", deq_count0 - c0); end
   endtask

   task automatic test_enable_drop();
      int gap, len, c0;
      logic [127:0] w;
      c0 = deq_count0;
      q0.push_back(8'h81);
      q0.push_back(8'h42);
      capture(0, 1'b1, gap, len, w);
      checks++; if (len !== 40 || wave_err(w, len, 16'b1100000010) !== 0) begin failures++; $display("FAIL drop_frame got len=%0d wave=%h", len, w[39:0]); end
      repeat (50) tick();
      checks++; if (deq_count0 - c0 !== 1 || q0.size() !== 1 || bus0.busy !== 1'b0) begin
         failures++; $display("FAIL drop_nopop got pops=%0d size=%0d exp pops=1 size=1", deq_count0 - c0, q0.size());
      end
      bus0.tx_enable = 1'b1;
      capture(0, 1'b0, gap, len, w);
      checks++; if (len !== 40 || wave_err(w, len, 16'b1010000100) !== 0) begin failures++; $display("FAIL drop_resume got len=%0d wave=%h", len, w[39:0]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_back_to_back();
      test_empty();
      test_disabled();
      test_reset_mid();
      test_enable_drop();
      checks++; if (deq_bad0 !== 0) begin failures++; $display("FAIL deq_protocol got=%0d exp=0", deq_bad0); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
